// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: core width, reset PC default,
// instruction field positions and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

    localparam int CORE_XLEN = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous DEPTH-entry FIFO with count/full/empty and a synchronous flush.
// Used for the instruction buffer ({pc, instr}) and the in-flight PC queue.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited in-order requests, buffers
// responses for decode and drains stale responses after a redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    fetch_state_e    r_state, w_state_nx;
    logic [XLEN-1:0] r_pc, w_pc_nx;
    logic [CW-1:0]   r_drop, w_drop_nx, w_out_nx;
    logic            w_accept, w_rsp, w_push, w_pop, w_flush;
    logic [CW-1:0]   w_buf_count, w_pcq_count;
    logic            w_buf_full, w_buf_empty, w_pcq_full, w_pcq_empty;
    logic [2*XLEN-1:0] w_buf_head;
    logic [XLEN-1:0] w_pcq_head;
    logic [CW:0]     w_inflight;

    // The PC queue occupancy is the outstanding-request count.
    assign w_inflight = {1'b0, w_buf_count} + {1'b0, w_pcq_count};

    assign imem_req_valid = rst && (r_state == ST_RUN) && !redirect_valid &&
                            !w_buf_full && !w_pcq_full && (w_inflight < CREDITS);
    assign imem_req_addr  = r_pc;

    assign w_accept = imem_req_valid && imem_req_ready;
    assign w_rsp    = imem_rsp_valid && !w_pcq_empty;
    assign w_pop    = instr_valid && instr_ready && !redirect_valid;
    assign w_out_nx = w_pcq_count + CW'(w_accept) - CW'(w_rsp);

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_drop_nx  = r_drop;
        w_push     = 1'b0;
        w_flush    = 1'b0;
        if (w_accept) w_pc_nx = r_pc + XLEN'(4);
        if (redirect_valid) begin
            w_flush    = 1'b1;
            w_pc_nx    = {redirect_pc[XLEN-1:2], 2'b00};
            w_drop_nx  = w_out_nx;
            w_state_nx = (w_out_nx != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   w_push = w_rsp;
                ST_FLUSH: begin
                    if (w_rsp) begin
                        w_drop_nx = r_drop - CW'(1);
                        if (r_drop == CW'(1)) w_state_nx = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_drop  <= w_drop_nx;
        end
    end

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (1'b0),
        .i_push  (w_accept),
        .i_data  (r_pc),
        .i_pop   (w_rsp),
        .o_head  (w_pcq_head),
        .o_count (w_pcq_count),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty)
    );

    fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_instr_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  ({w_pcq_head, imem_rsp_data}),
        .i_pop   (w_pop),
        .o_head  (w_buf_head),
        .o_count (w_buf_count),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty)
    );

    assign instr_valid = !w_buf_empty;
    assign instr       = w_buf_head[XLEN-1:0];
    assign instr_pc    = w_buf_head[2*XLEN-1:XLEN];
    assign op          = instr[OP_MSB:OP_LSB];
    assign funct3      = instr[F3_MSB:F3_LSB];
    assign funct7      = instr[F7_MSB:F7_LSB];

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> !w_pcq_empty);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit with an in-order memory
// model and an expected-PC-stream scoreboard.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;

    logic        w_req_valid, w_rsp_valid, w_instr_valid;
    logic [31:0] w_req_addr, w_instr, w_instr_pc;
    logic [6:0]  w_op, w_funct7;
    logic [2:0]  w_funct3;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .op(op), .funct3(funct3), .funct7(funct7)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(32'h0050_0093), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .instr_valid(w_instr_valid),
        .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_instr_pc),
        .op(w_op), .funct3(w_funct3), .funct7(w_funct7)
    );

    // Wrap instance memory: always ready, answers one cycle after acceptance.
    always @(posedge clk or negedge rst) begin
        if (!rst) w_rsp_valid <= 1'b0;
        else      w_rsp_valid <= w_req_valid;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] wrap_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    bit          rnd_ready = 0;
    bit          fixed_data = 1;
    logic [31:0] exp_pc = 32'h0, exp_req_pc = 32'h0;
    int          live = 0;
    int          npops = 0;
    int          acc_cnt = 0;
    int          first_acc_cyc = -1, first_val_cyc = -1;
    bit          want_first = 0, track_req = 0;
    logic [31:0] first_pop_pc = 32'hFFFF_FFFF, first_req_addr = 32'hFFFF_FFFF;
    int          stale_at_req = -1;
    bit          arm = 0, arm_hit = 0;
    logic [31:0] arm_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return fixed_data ? 32'h0050_0093 : ((a * 32'h9E37_79B1) ^ 32'h0050_0093);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        logic [31:0] w;
        if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        imem_req_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (arm && imem_rsp_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = arm_pc;
            arm = 0; arm_hit = 1; want_first = 1;
        end
        #1;
        if (rst) begin
            if (redirect_valid) chk("no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_req_pc);
                chk("credit", {31'b0, live < DEPTH}, 32'd1);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (track_req) begin
                    first_req_addr = imem_req_addr;
                    stale_at_req = mq.size();
                    track_req = 0;
                end
                mq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_min, lat_max))});
                exp_req_pc += 32'd4;
                live++;
                acc_cnt++;
            end
            if (imem_rsp_valid) void'(mq.pop_front());
            if (instr_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
                exp_req_pc = exp_pc;
                live = 0;
            end else if (instr_valid && instr_ready) begin
                w = mem_word(exp_pc);
                chk("instr_pc", instr_pc, exp_pc);
                chk("instr", instr, w);
                chk("op", {25'b0, op}, w & 32'h7F);
                chk("funct3", {29'b0, funct3}, (w >> 12) & 32'h7);
                chk("funct7", {25'b0, funct7}, w >> 25);
                if (want_first) begin
                    first_pop_pc = instr_pc;
                    want_first = 0;
                end
                exp_pc += 32'd4;
                live--;
                npops++;
            end
            if (w_req_valid && wrap_q.size() < 3) wrap_q.push_back(w_req_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc = t;
        want_first = 1;
        track_req = 1;
        tick();
    endtask

    task automatic run_pops(input int n, input int budget, input string tag);
        int target;
        int k;
        target = npops + n;
        k = 0;
        while (npops < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'b0, npops >= target}, 32'd1);
    endtask

    task automatic wait_two_outstanding(input string tag);
        int k;
        k = 0;
        while (!(mq.size() == 2 && mq[0].due > cyc + 2) && k < 60) begin
            tick();
            k++;
        end
        chk(tag, {31'b0, mq.size() == 2}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;
        #2;
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic streaming with a 1-cycle memory.
        run_pops(6, 100, "stream_progress");
        chk("first_valid_latency", first_val_cyc - first_acc_cyc, 32'd2);

        // Backpressure from a clean redirect point.
        instr_ready = 1'b0;
        fixed_data = 0;
        acc_cnt = 0;
        do_redirect(32'h40);
        repeat (10) tick();
        chk("bp_req_count", acc_cnt, DEPTH);
        chk("bp_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
        chk("bp_instr_valid", {31'b0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        run_pops(DEPTH + 4, 100, "bp_release_progress");
        chk("bp_first_pc", first_pop_pc, 32'h40);

        // Redirect with two requests in flight.
        lat_min = 5; lat_max = 5;
        wait_two_outstanding("two_outstanding_a");
        do_redirect(32'h100);
        chk("flush_no_req", {31'b0, imem_req_valid}, 32'd0);
        run_pops(3, 100, "flush_progress");
        chk("flush_drained", stale_at_req, 32'd0);
        chk("flush_first_pc", first_pop_pc, 32'h100);

        // Redirect landing on a response cycle.
        lat_min = 1; lat_max = 1;
        arm_pc = 32'h300;
        arm_hit = 0;
        arm = 1;
        for (int k = 0; k < 50 && !arm_hit; k++) tick();
        chk("coincide_hit", {31'b0, arm_hit}, 32'd1);
        run_pops(3, 100, "coincide_progress");
        chk("coincide_first_pc", first_pop_pc, 32'h300);

        // Unaligned redirect target.
        do_redirect(32'h203);
        run_pops(3, 100, "unaligned_progress");
        chk("unaligned_first_req", first_req_addr, 32'h200);
        chk("unaligned_first_pc", first_pop_pc, 32'h200);

        // Random traffic.
        rnd_ready = 1;
        lat_min = 1; lat_max = 4;
        begin
            int start;
            start = npops;
            for (int k = 0; k < 400; k++) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc = $urandom_range(0, 32'h0000_FFFF);
                end
                tick();
            end
            chk("random_progress", {31'b0, npops > start + 20}, 32'd1);
        end

        // Reset asserted while draining stale responses.
        rnd_ready = 0;
        instr_ready = 1'b1;
        lat_min = 6; lat_max = 6;
        wait_two_outstanding("two_outstanding_b");
        do_redirect(32'h500);
        tick();
        chk("pre_reset_in_flush", {31'b0, imem_req_valid}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("midreset_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("midreset_req_addr", imem_req_addr, 32'h0);
        mq.delete();
        exp_pc = 32'h0;
        exp_req_pc = 32'h0;
        live = 0;
        want_first = 0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        lat_min = 1; lat_max = 1;
        want_first = 1;
        track_req = 1;
        run_pops(3, 100, "restart_progress");
        chk("restart_first_req", first_req_addr, 32'h0);
        chk("restart_first_pc", first_pop_pc, 32'h0);

        // PC wrap on the second instance.
        chk("wrap_count", wrap_q.size(), 32'd3);
        if (wrap_q.size() == 3) begin
            chk("wrap_addr0", wrap_q[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", wrap_q[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", wrap_q[2], 32'h0000_0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
